iot_out_ser: RTL

Downstream output stage for the IOTDF filter. Captures each 128-bit `iot_out` word on the IOTDF's single-cycle `valid` pulse and buffers it in a small word FIFO, because IOTDF has no back-pressure input. Each buffered word is serialized MSB byte first onto an 8-bit valid/ready link toward the host interface. A sticky overflow flag records any word lost while the buffer was full.

---
 rtl/iot_out_ser_pkg.sv | 12 +
 rtl/iot_out_ser_if.sv | 27 ++
 rtl/iot_word_fifo.sv | 50 +++++
 rtl/iot_out_ser.sv | 93 +++++++++
 4 files changed

// File: rtl/iot_out_ser_pkg.sv
// Shared constants and types for the IOTDF output serializer.
package iot_pkg;
    localparam int WORD_W = 128;
    localparam int BYTE_W = 8;
    localparam int BEATS  = WORD_W / BYTE_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;
endpackage

// File: rtl/iot_out_ser_if.sv
// Word-in / byte-out bundle of the serializer; slave is the design side.
interface iot_out_ser_if #(
    parameter int DEPTH = 4
);
    import iot_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              valid_in;
    logic [WORD_W-1:0] data_in;
    logic              tx_ready;
    logic              tx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_last;
    logic              ovf;
    logic [CNT_W-1:0]  count;

    modport master (
        output valid_in, data_in, tx_ready,
        input  tx_valid, tx_data, tx_last, ovf, count
    );

    modport slave (
        input  valid_in, data_in, tx_ready,
        output tx_valid, tx_data, tx_last, ovf, count
    );
endinterface

// File: rtl/iot_word_fifo.sv
// Word FIFO with wrap-bit pointers; the head word is visible combinationally.
module iot_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      ptr_diff;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en, rd_en;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign ptr_diff = wr_ptr_q - rd_ptr_q;
    assign count    = CW'(ptr_diff);
    assign rdata    = mem[rd_ptr_q[AW-1:0]];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end
endmodule

// File: rtl/iot_out_ser.sv
// IOTDF output stage: buffers 128-bit words and streams them MSB byte first.
module iot_out_ser
    import iot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    iot_out_ser_if.slave  bus
);
    ser_state_t               state_q, state_d;
    logic [WORD_W-1:0]        shreg_q, shreg_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     ovf_q, ovf_d;
    logic                     pop;
    logic                     fifo_full, fifo_empty;
    logic [WORD_W-1:0]        fifo_head;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic                     last_beat;

    iot_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.valid_in),
        .pop   (pop),
        .wdata (bus.data_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    shreg_d = fifo_head;
                    beat_d  = '0;
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (last_beat && !fifo_empty) begin
                        // Reload on the last beat keeps words gap-free.
                        shreg_d = fifo_head;
                        beat_d  = '0;
                        pop     = 1'b1;
                    end else if (last_beat) begin
                        shreg_d = shreg_q << BYTE_W;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        shreg_d = shreg_q << BYTE_W;
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ovf_d = ovf_q | (bus.valid_in && fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.tx_valid = (state_q == SEND);
    assign bus.tx_data  = shreg_q[WORD_W-1 -: BYTE_W];
    assign bus.tx_last  = (state_q == SEND) && last_beat;
    assign bus.ovf      = ovf_q;
    assign bus.count    = fifo_count;
endmodule
